// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response and the
// decode-side valid/ready handshake.
interface if_fetch_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [63:0] id_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    output id_valid, id_instr, id_pc,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    input  id_valid, id_instr, id_pc,
    output id_ready
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: one outstanding imem request, 2-entry decode queue,
// redirect flush. Optional fetch_count port enabled by IF_FETCH_PERF_EN.
module if_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc,
  output logic [63:0] pc_next,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  if_fetch_if.master  bus
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_nx;
  logic        drop, drop_nx;
  logic [63:0] pend_pc;
  logic [31:0] q_instr [2];
  logic [63:0] q_pc    [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        issue, push, pop;

  always_comb begin
    issue    = (state == IDLE) && (count != 2'd2) && !redirect;
    push     = (state == WAIT) && bus.imem_rvalid && !drop && !redirect;
    pop      = (count != 2'd0) && bus.id_ready;
    state_nx = state;
    drop_nx  = drop;
    unique case (state)
      IDLE: if (issue) state_nx = WAIT;
      WAIT: begin
        if (bus.imem_rvalid) begin
          state_nx = IDLE;
          drop_nx  = 1'b0;
        end else if (redirect) begin
          drop_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request and next-PC are gated by rst so they show reset values immediately.
  always_comb begin
    bus.imem_req  = rst && issue;
    bus.imem_addr = bus.imem_req ? pc : '0;
    if (!rst)          pc_next = RESET_PC;
    else if (redirect) pc_next = redirect_pc & ~64'h3;
    else if (issue)    pc_next = pc + 64'd4;
    else               pc_next = pc;
  end

  always_comb begin
    bus.id_valid = (count != 2'd0);
    bus.id_instr = q_instr[rd_ptr];
    bus.id_pc    = q_pc[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      drop    <= 1'b0;
      pend_pc <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      state <= state_nx;
      drop  <= drop_nx;
      if (issue) pend_pc <= pc;
      if (redirect) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= '0;
      end else begin
        if (push) begin
          q_instr[wr_ptr] <= bus.imem_rdata;
          q_pc[wr_ptr]    <= pend_pc;
          wr_ptr          <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        unique case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     fetch_count <= '0;
    else if (pop) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: a queue-based reference model predicts every
// output each cycle; a latency-randomized memory answers requests.
module tb_if_fetch;
  localparam logic [63:0] RST_PC = 64'h1000;
  localparam int NCYC = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic [63:0] pc_next;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] fetch_count;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_next    (pc_next),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .bus        (bus)
`ifdef IF_FETCH_PERF_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Reference model state
  entry_t      q[$];
  bit          outst;
  bit          drop_m;
  logic [63:0] pend_m;
  logic [31:0] cnt_m;

  // Memory model state
  bit          mem_pend;
  int unsigned mem_cnt;
  logic [63:0] mem_addr;

  // DUT outputs sampled mid-cycle, used by environment at the next edge
  logic        s_req;
  logic [63:0] s_addr;
  logic [63:0] s_next;

  int          reset_until;
  bit          did_mid;

  function automatic logic [31:0] instr_at(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    q.delete();
    outst  = 0;
    drop_m = 0;
    pend_m = '0;
    cnt_m  = '0;
  endtask

  task automatic check_outputs();
    bit          issue;
    logic [63:0] exp_next;
    if (!rst) begin
      check("rst_imem_req",  bus.imem_req,  1'b0);
      check("rst_imem_addr", bus.imem_addr, 64'h0);
      check("rst_pc_next",   pc_next,       RST_PC);
      check("rst_id_valid",  bus.id_valid,  1'b0);
      check("rst_id_pc",     bus.id_pc,     64'h0);
      check("rst_id_instr",  bus.id_instr,  32'h0);
    end else begin
      issue    = !outst && (q.size() < 2) && !redirect;
      exp_next = redirect ? {redirect_pc[63:2], 2'b00} : (issue ? pc + 64'd4 : pc);
      check("imem_req", bus.imem_req, issue);
      if (issue) check("imem_addr", bus.imem_addr, pc);
      check("pc_next",  pc_next,      exp_next);
      check("id_valid", bus.id_valid, q.size() != 0);
      if (q.size() != 0) begin
        check("id_pc",    bus.id_pc,    q[0].pc);
        check("id_instr", bus.id_instr, q[0].instr);
      end
    end
`ifdef IF_FETCH_PERF_EN
    check("fetch_count", fetch_count, cnt_m);
`endif
  endtask

  task automatic update_model();
    bit     issue, pop, push;
    entry_t e;
    if (!rst) return;
    issue = !outst && (q.size() < 2) && !redirect;
    pop   = (q.size() != 0) && bus.id_ready;
    push  = outst && bus.imem_rvalid && !drop_m && !redirect;
    if (pop) cnt_m++;
    if (redirect) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.pc    = pend_m;
        e.instr = bus.imem_rdata;
        q.push_back(e);
      end
    end
    if (outst) begin
      if (bus.imem_rvalid) begin
        outst  = 0;
        drop_m = 0;
      end else if (redirect) begin
        drop_m = 1;
      end
    end else if (issue) begin
      outst  = 1;
      pend_m = pc;
    end
  endtask

  task automatic update_mem();
    if (mem_pend) begin
      if (mem_cnt == 0) mem_pend = 0;
      else mem_cnt--;
    end
    if (s_req) begin
      mem_pend = 1;
      mem_cnt  = $urandom_range(0, 2);
      mem_addr = s_addr;
    end
  endtask

  task automatic drive_inputs(input int cyc);
    if (cyc < 4) begin
      rst = 1'b0;
    end else if (cyc < reset_until) begin
      rst = 1'b0;
    end else if (!did_mid && cyc >= 1500 && outst && mem_pend && mem_cnt == 1) begin
      // Reset mid-WAIT; the abandoned response lands after release while idle.
      did_mid     = 1;
      reset_until = cyc + 1;
      rst         = 1'b0;
      model_reset();
      #1;
      check_outputs();
    end else begin
      rst = 1'b1;
    end

    if (cyc < 260) begin
      redirect    = 1'b0;
      bus.id_ready = (cyc < 200);
    end else if (cyc == 300) begin
      redirect     = 1'b1;
      redirect_pc  = '1;
      bus.id_ready = 1'b1;
    end else begin
      redirect     = (cyc > 320) && ($urandom_range(0, 11) == 0);
      redirect_pc  = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 32'($urandom)}
                                                 : {32'($urandom), 32'($urandom)};
      bus.id_ready = ($urandom_range(0, 3) != 0);
    end

    bus.imem_rvalid = mem_pend && (mem_cnt == 0);
    bus.imem_rdata  = bus.imem_rvalid ? instr_at(mem_addr) : 32'($urandom);
  endtask

  initial begin
    rst             = 1'b0;
    pc              = '0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    bus.id_ready    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    mem_pend        = 0;
    mem_cnt         = 0;
    mem_addr        = '0;
    reset_until     = 0;
    did_mid         = 0;
    model_reset();
    #1;
    check_outputs();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      drive_inputs(cyc);
      @(negedge clk);
      check_outputs();
      s_req  = bus.imem_req;
      s_addr = bus.imem_addr;
      s_next = pc_next;
      @(posedge clk);
      update_model();
      update_mem();
      #1;
      pc = s_next;
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage sitting directly downstream of the 64-bit `PC` register: it reads the current PC, issues instruction-memory requests, and returns the next-PC value to the `PC` register's `IN`. Fetched instructions are buffered with their PC in a 2-entry queue and handed to decode over a valid/ready handshake. Branch/jump redirects flush the queue and discard any in-flight response.

## Interface
- `RESET_PC`, 64'h0: value driven on `pc_next` while in reset.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `pc`  in  64: current PC, from `PC.OUT`.
- `pc_next`  out  64: next PC, to `PC.IN`.
- `redirect`  in  1: flush and redirect request from execute.
- `redirect_pc`  in  64: redirect target; bits [1:0] forced to 0.
- `imem_req`  out  1: one-cycle request pulse, always accepted by memory.
- `imem_addr`  out  64: request address, valid while `imem_req`=1.
- `imem_rvalid`  in  1: response valid, ≥1 cycle after the request.
- `imem_rdata`  in  32: instruction word.
- `id_valid`  out  1: queue head valid toward decode.
- `id_ready`  in  1: decode accepts head.
- `id_instr`  out  32: head instruction.
- `id_pc`  out  64: head PC.
- `fetch_count`  out  32: present only with `IF_FETCH_PERF_EN`.

## Operation
- FSM states: IDLE (no request outstanding), WAIT (one request outstanding). At most one outstanding request.
- IDLE: when queue count < 2 and `redirect`=0, assert `imem_req`, `imem_addr`=`pc`, latch `pend_pc`=`pc`, `pc_next`=`pc`+4, go to WAIT. Otherwise `pc_next`=`pc`.
- WAIT: `pc_next`=`pc`. On `imem_rvalid`, push {`pend_pc`, `imem_rdata`} unless the drop flag is set; clear drop; go to IDLE.
- `redirect`=1 (any state): `pc_next`={`redirect_pc`[63:2],2'b00}; queue emptied; no request issued that cycle; if in WAIT with no `imem_rvalid` that cycle, set drop so the pending response is discarded. A redirect coinciding with `imem_rvalid` discards that response and returns to IDLE.
- Queue: 2-entry FIFO. Pop when `id_valid`&&`id_ready`. Simultaneous push and pop keeps count. Push never occurs when full (request gating guarantees it). `id_instr`/`id_pc` undefined-but-stable when `id_valid`=0; hold stable while `id_valid`&&!`id_ready`.
- PC arithmetic: 64-bit modulo add; 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
- Reset (async, `rst`=0): state IDLE, queue empty, drop=0, `imem_req`=0, `imem_addr`=0, `id_valid`=0, `id_instr`=0, `id_pc`=0, `pc_next`=`RESET_PC`, `fetch_count`=0. Reset mid-WAIT abandons the request; later `imem_rvalid` while in IDLE is ignored.

## Timing
- `imem_req`/`imem_addr` combinational from state, `pc`, queue count, and `redirect`; `pc_next` combinational.
- Request cycle N, `imem_rvalid` at N+k (k≥1), `id_valid`=1 at N+k+1 (registered queue).
- Back-to-back issue: IDLE is re-entered the cycle after the response, so peak throughput is one instruction per 2 cycles with k=1.
- Redirect at cycle R: `pc_next`=target at R; PC register holds target at R+1; first request at R+1.

## Configuration
- `IF_FETCH_PERF_EN` defined: `fetch_count` port exists, increments by 1 on every decode handshake (`id_valid`&&`id_ready`), wraps at 2^32, resets to 0, not cleared by redirect.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset with `RESET_PC`=64'h1000, then release; memory k=1 returns 32'h00000013 for every address -> requests at 0x1000, 0x1004, 0x1008; decode receives `id_pc`=0x1000, 0x1004 in order with `id_instr`=32'h00000013.
- `id_ready`=0 held -> exactly 2 entries queue, `imem_req` stays 0, `pc_next`=`pc`; raise `id_ready` -> both drain in order, fetching resumes.
- `redirect`=1, `redirect_pc`=64'h2003 while in WAIT, response arrives 2 cycles later -> response dropped, queue empty, next `imem_addr`=0x2000.
- `redirect` in the same cycle as `imem_rvalid` -> no push, `id_valid` stays 0, next request at target.
- `pc`=64'hFFFF_FFFF_FFFF_FFFC in IDLE -> `pc_next`=0.
- With `IF_FETCH_PERF_EN`: 5 handshakes -> `fetch_count`=5; assert `rst`=0 mid-WAIT -> all outputs at reset values immediately, `fetch_count`=0.
